// File: rtl/counter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | counter_pkg: mode encodings and seed/bit-reverse helpers for          |
// | multimode_counter.                                                     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package counter_pkg;

    localparam int c_min_width = 2;
    localparam int c_max_width = 32;

    typedef enum logic [2:0] {
        MODE_BIN     = 3'd0,
        MODE_RING    = 3'd1,
        MODE_JOHNSON = 3'd2,
        MODE_ALT     = 3'd3
    } mode_e;

    function automatic logic mode_reserved(input logic [2:0] mode);
        return (mode > 3'd3);
    endfunction

    // Reserved modes have no sequence of their own; they seed to zero.
    function automatic logic [31:0] seed(input logic [2:0] mode, input int width);
        logic [31:0] msb_one_hot;
        msb_one_hot = 32'd1 << (width - 1);
        case (mode)
            MODE_RING, MODE_ALT: return msb_one_hot;
            default:             return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] bit_reverse(input logic [31:0] value, input int width);
        logic [31:0] result;
        result = 32'd0;
        for (int i = 0; i < c_max_width; i++) begin
            if (i < width) begin
                result[i] = value[width - 1 - i];
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_rotator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ring_rotator: combinational one-bit rotate of a WIDTH-bit vector.     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module ring_rotator #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_toward_msb,
    output logic [WIDTH-1:0] o_value
);

    assign o_value = i_toward_msb ? {i_value[WIDTH-2:0], i_value[WIDTH-1]}
                                  : {i_value[0], i_value[WIDTH-1:1]};

endmodule
`default_nettype wire

// File: rtl/multimode_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multimode_counter: run-time selectable binary/ring/Johnson/alternating |
// | counter with registered terminal-count pulse and mode error flag.      |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module multimode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_cnt_enable_n,
    input  logic             i_ld_enable_n,
    input  logic [WIDTH-1:0] i_load,
    input  logic [2:0]       i_mode,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_mode_err
);

    localparam logic [WIDTH-1:0] c_msb = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_lsb = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};

    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_down;
    logic [WIDTH-1:0] r_up;
    logic             r_toggle;
    logic             r_tc;
    logic             r_mode_err;

    logic [WIDTH-1:0] w_seed_in;
    logic [WIDTH-1:0] w_load_rev;
    logic [WIDTH-1:0] w_ring_rot;
    logic [WIDTH-1:0] w_up_rot;
    logic [WIDTH-1:0] w_down_rot;
    logic [WIDTH-1:0] w_count_next;
    logic             w_tc_next;
    logic             w_in_reserved;

    assign w_seed_in     = WIDTH'(seed(i_mode, WIDTH));
    assign w_load_rev    = WIDTH'(bit_reverse(32'(i_load), WIDTH));
    assign w_in_reserved = mode_reserved(i_mode);

    ring_rotator #(.WIDTH(WIDTH)) u_ring_rot (
        .i_value      (r_count),
        .i_toward_msb (i_dir),
        .o_value      (w_ring_rot)
    );

    ring_rotator #(.WIDTH(WIDTH)) u_up_rot (
        .i_value      (r_up),
        .i_toward_msb (1'b1),
        .o_value      (w_up_rot)
    );

    ring_rotator #(.WIDTH(WIDTH)) u_down_rot (
        .i_value      (r_down),
        .i_toward_msb (1'b0),
        .o_value      (w_down_rot)
    );

    always_comb begin
        w_count_next = r_count;
        w_tc_next    = 1'b0;
        case (r_mode)
            MODE_BIN: begin
                if (i_dir) begin
                    w_count_next = r_count - 1'b1;
                    w_tc_next    = (r_count == '0);
                end else begin
                    w_count_next = r_count + 1'b1;
                    w_tc_next    = (r_count == c_max);
                end
            end
            MODE_RING: begin
                // An all-zero pattern (only reachable by load) would never rotate out.
                if (r_count == '0) begin
                    w_count_next = c_msb;
                end else begin
                    w_count_next = w_ring_rot;
                    w_tc_next    = (w_ring_rot == c_msb);
                end
            end
            MODE_JOHNSON: begin
                w_count_next = {~r_count[0], r_count[WIDTH-1:1]};
                w_tc_next    = ({~r_count[0], r_count[WIDTH-1:1]} == '0);
            end
            MODE_ALT: begin
                w_count_next = r_toggle ? r_up : r_down;
                w_tc_next    = r_toggle && (w_down_rot == c_msb);
            end
            default: begin
                w_count_next = r_count;
                w_tc_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_mode     <= i_mode;
            r_count    <= w_seed_in;
            r_down     <= c_msb;
            r_up       <= c_lsb;
            r_toggle   <= 1'b1;
            r_tc       <= 1'b0;
            r_mode_err <= w_in_reserved;
        end else if (i_mode != r_mode) begin
            // Entering a reserved mode keeps the current count frozen.
            r_mode     <= i_mode;
            if (!w_in_reserved) begin
                r_count <= w_seed_in;
            end
            r_down     <= c_msb;
            r_up       <= c_lsb;
            r_toggle   <= 1'b1;
            r_tc       <= 1'b0;
            r_mode_err <= w_in_reserved;
        end else if (!i_ld_enable_n) begin
            r_count <= i_load;
            r_tc    <= 1'b0;
            if (r_mode == MODE_ALT) begin
                r_down   <= i_load;
                r_up     <= w_load_rev;
                r_toggle <= 1'b1;
            end
        end else if (!i_cnt_enable_n) begin
            r_count <= w_count_next;
            r_tc    <= w_tc_next;
            if (r_mode == MODE_ALT) begin
                r_toggle <= ~r_toggle;
                if (r_toggle) begin
                    r_up   <= w_up_rot;
                    r_down <= w_down_rot;
                end
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign o_count    = r_count;
    assign o_tc       = r_tc;
    assign o_mode_err = r_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_multimode_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_multimode_counter: directed checks of a 4-bit and an 8-bit counter  |
// | driven from one shared set of controls.                                |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_multimode_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cnt_en_n;
    logic       ld_en_n;
    logic [7:0] load;
    logic [2:0] mode;
    logic       dir;

    logic [3:0] count4;
    logic       tc4;
    logic       err4;
    logic [7:0] count8;
    logic       tc8;
    logic       err8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] johnson_exp [8] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};
    logic [7:0] ring_exp    [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    logic [7:0] alt_exp     [12] = '{8'h04, 8'h10, 8'h08, 8'h08, 8'h10, 8'h04,
                                     8'h20, 8'h02, 8'h40, 8'h01, 8'h80, 8'h80};

    always #5 clk = ~clk;

    multimode_counter #(.WIDTH(4)) u_dut4 (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_cnt_enable_n (cnt_en_n),
        .i_ld_enable_n  (ld_en_n),
        .i_load         (load[3:0]),
        .i_mode         (mode),
        .i_dir          (dir),
        .o_count        (count4),
        .o_tc           (tc4),
        .o_mode_err     (err4)
    );

    multimode_counter #(.WIDTH(8)) u_dut8 (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_cnt_enable_n (cnt_en_n),
        .i_ld_enable_n  (ld_en_n),
        .i_load         (load),
        .i_mode         (mode),
        .i_dir          (dir),
        .o_count        (count8),
        .o_tc           (tc8),
        .o_mode_err     (err8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        cnt_en_n = 1'b1;
        ld_en_n  = 1'b1;
        load     = 8'h00;
        mode     = 3'd0;
        dir      = 1'b0;

        // Binary, 4 bits
        tick();
        check("rst_bin4_count", count4, 4'h0);
        check("rst_bin4_tc", tc4, 1'b0);
        check("rst_bin4_err", err4, 1'b0);
        check("rst_bin8_count", count8, 8'h00);
        reset_n  = 1'b1;
        cnt_en_n = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("bin4_up_%0d", i), count4, 32'(i % 16));
            check($sformatf("bin4_up_tc_%0d", i), tc4, (i == 16) ? 1 : 0);
        end
        dir = 1'b1;
        tick();
        check("bin4_down_wrap", count4, 4'hF);
        check("bin4_down_wrap_tc", tc4, 1'b1);
        reset_n = 1'b0;
        tick();
        check("bin4_midrst_count", count4, 4'h0);
        check("bin4_midrst_tc", tc4, 1'b0);

        // Ring, 8 bits
        mode     = 3'd1;
        dir      = 1'b0;
        cnt_en_n = 1'b1;
        tick();
        check("rst_ring8", count8, 8'h80);
        reset_n  = 1'b1;
        cnt_en_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("ring8_%0d", i), count8, ring_exp[i]);
            check($sformatf("ring8_tc_%0d", i), tc8, (i == 7) ? 1 : 0);
        end
        reset_n = 1'b0;
        tick();
        check("ring8_midrst_count", count8, 8'h80);
        check("ring8_midrst_tc", tc8, 1'b0);
        reset_n = 1'b1;
        ld_en_n = 1'b0;
        load    = 8'h00;
        tick();
        check("ring8_load_zero", count8, 8'h00);
        check("ring8_load_tc", tc8, 1'b0);
        ld_en_n = 1'b1;
        tick();
        check("ring8_recover", count8, 8'h80);
        dir = 1'b1;
        tick();
        check("ring8_to_msb", count8, 8'h01);

        // Johnson, 4 bits
        dir      = 1'b0;
        mode     = 3'd2;
        reset_n  = 1'b0;
        cnt_en_n = 1'b1;
        tick();
        check("rst_john4", count4, 4'h0);
        reset_n  = 1'b1;
        cnt_en_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("john4_%0d", i), count4, johnson_exp[i]);
            check($sformatf("john4_tc_%0d", i), tc4, (i == 7) ? 1 : 0);
        end
        dir = 1'b1;
        tick();
        check("john4_dir_ignored", count4, 4'h8);
        reset_n = 1'b0;
        tick();
        check("john4_midrst_count", count4, 4'h0);
        check("john4_midrst_tc", tc4, 1'b0);

        // Alternating ring, 8 bits
        dir      = 1'b0;
        mode     = 3'd3;
        cnt_en_n = 1'b1;
        tick();
        check("rst_alt8", count8, 8'h80);
        reset_n  = 1'b1;
        cnt_en_n = 1'b0;
        tick();
        check("alt8_1", count8, 8'h01);
        tick();
        check("alt8_2", count8, 8'h40);
        tick();
        check("alt8_3", count8, 8'h02);
        tick();
        check("alt8_4", count8, 8'h20);
        cnt_en_n = 1'b1;
        tick();
        tick();
        tick();
        check("alt8_hold", count8, 8'h20);
        check("alt8_hold_tc", tc8, 1'b0);
        cnt_en_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("alt8_%0d", i + 5), count8, alt_exp[i]);
            check($sformatf("alt8_tc_%0d", i + 5), tc8, (i == 10) ? 1 : 0);
        end
        ld_en_n = 1'b0;
        load    = 8'h03;
        tick();
        check("alt8_load", count8, 8'h03);
        ld_en_n = 1'b1;
        tick();
        check("alt8_load_up", count8, 8'hC0);
        tick();
        check("alt8_load_down", count8, 8'h81);
        reset_n = 1'b0;
        tick();
        check("alt8_midrst_count", count8, 8'h80);
        check("alt8_midrst_tc", tc8, 1'b0);
        reset_n = 1'b1;
        tick();
        check("alt8_after_rst", count8, 8'h01);

        // Mode change outranks load and count
        mode = 3'd0;
        tick();
        check("sw_to_bin_count", count8, 8'h00);
        check("sw_to_bin_err", err8, 1'b0);
        mode    = 3'd1;
        ld_en_n = 1'b0;
        load    = 8'h55;
        tick();
        check("sw_to_ring_count", count8, 8'h80);
        check("sw_to_ring_tc", tc8, 1'b0);
        ld_en_n = 1'b1;

        // Reserved mode
        mode = 3'd5;
        tick();
        check("rsv_hold_count", count8, 8'h80);
        check("rsv_err", err8, 1'b1);
        tick();
        check("rsv_hold_count2", count8, 8'h80);
        check("rsv_tc", tc8, 1'b0);
        reset_n = 1'b0;
        tick();
        check("rsv_rst_err", err8, 1'b1);
        check("rsv_rst_tc", tc8, 1'b0);
        reset_n = 1'b1;
        mode    = 3'd0;
        tick();
        check("rsv_exit_err", err8, 1'b0);
        check("rsv_exit_count", count8, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multimode_counter.md
# multimode_counter

Parametrised, run-time mode-selectable counter covering binary up/down, one-hot ring, Johnson and alternating up/down ring sequences behind one set of control pins. It is the general counter primitive for the course designs and replaces the separate fixed-width binary and ring counters. Output is registered, with a one-cycle terminal-count pulse for cascading or for driving display and LED sequencers.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..32.
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_cnt_enable_n  in  1  active-low count enable.
- i_ld_enable_n  in  1  active-low synchronous parallel load.
- i_load  in  WIDTH  parallel load value.
- i_mode  in  3  mode select:
  - 0 = binary
  - 1 = ring
  - 2 = Johnson
  - 3 = alternating ring
  - 4..7 = reserved
- i_dir  in  1  direction:
  - binary: 0 = up, 1 = down
  - ring: 0 = rotate toward LSB, 1 = rotate toward MSB
  - ignored in modes 2 and 3
- o_count  out  WIDTH  registered count.
- o_tc  out  1  registered terminal-count pulse.
- o_mode_err  out  1  registered; high while the latched mode is reserved.

## Operation
- Seed values (SEED(m)):
  - binary: 0
  - ring: MSB one-hot (1 in bit WIDTH-1)
  - Johnson: 0
  - alternating: MSB one-hot
- Internal state: r_mode (latched mode), r_down, r_up, r_toggle (alternating mode only).
- Priority per edge: reset > mode change > load > count > hold.
- Reset:
  - r_mode = i_mode; o_count = SEED(i_mode).
  - r_down = MSB one-hot, r_up = LSB one-hot, r_toggle = 1.
  - o_tc = 0; o_mode_err = (i_mode > 3).
- Mode change (i_mode != r_mode): latch the new mode, o_count = SEED(new), reinitialise the alternating state as at reset, o_tc = 0. No load or count occurs that cycle.
- Load (i_ld_enable_n = 0):
  - o_count = i_load.
  - In alternating mode: r_down = i_load, r_up = bit-reverse(i_load), r_toggle = 1.
  - Load with enable active does not also count.
- Count (enable active, no load):
  - Binary: ±1 modulo 2^WIDTH.
  - Ring: 1-bit rotate. If o_count == 0, reload the seed instead (self-recovery from a bad load).
  - Johnson: shift toward LSB; MSB receives ~LSB. Period is 2·WIDTH.
  - Alternating:
    - r_toggle = 1: o_count = r_up; then r_up rotates toward MSB and r_down rotates toward LSB.
    - r_toggle = 0: o_count = r_down.
    - r_toggle inverts on every enabled cycle.
  - Reserved modes: hold o_count; o_mode_err = 1.
- o_tc is high for exactly one cycle, on the edge where the count wraps:
  - binary up: max→0; binary down: 0→max.
  - ring: the rotate that lands on SEED.
  - Johnson: the shift that lands on 0.
  - alternating: the update in which r_down returns to MSB one-hot.
  - Never on load, reset, or mode change.

## Timing
- All outputs are registered; zero combinational input-to-output paths.
- Latency from control to output is 1 cycle: an enable sampled at edge k is reflected in o_count after edge k.
- o_tc coincides with the o_count wrap value (same edge).
- Mode change takes effect in 1 cycle, and the first count in the new mode happens on the following enabled edge.
- Enable held inactive freezes all state, including r_toggle.

## Structure
- Package counter_pkg holds:
  - mode encodings (MODE_BIN, MODE_RING, MODE_JOHNSON, MODE_ALT)
  - function seed(mode, width)
  - function bit_reverse.
- One natural sub-module, ring_rotator: parametrised WIDTH, direction input, next-state rotate logic. It is instantiated for ring mode, r_up and r_down.

## Test plan
- WIDTH=4, mode 0, i_dir=0, reset then 16 enables:
  - o_count 0→F→0.
  - o_tc high only on the edge giving 0 (16th).
  - Then i_dir=1 from 0: next value F with o_tc=1.
- WIDTH=8, mode 1, i_dir=0, reset → 0x80; 8 enables:
  - sequence 0x40, 0x20 … 0x01, 0x80.
  - o_tc on the 0x80 edge.
  - Load 0x00 then enable → 0x80.
- WIDTH=4, mode 2, reset → 0; 8 enables:
  - sequence 8, C, E, F, 7, 3, 1, 0.
  - o_tc on the final edge only.
- WIDTH=8, mode 3, reset → 0x80; 4 enables:
  - sequence 0x01, 0x40, 0x02, 0x20.
  - Disable for 3 cycles: holds 0x20, and the next enable gives 0x04.
- Mode switch 0→1 with load and enable both active: o_count = 0x80 (seed wins), o_tc = 0.
- Mode 5 selected: o_count holds and o_mode_err = 1 one cycle later. Assert reset mid-sequence in every mode: seed value and o_tc = 0 on the next edge.
